mem_sweep_ctrl: RTL and testbench



---
 rtl/mem_sweep_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_sweep_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sweep_ctrl.sv
// Triangular-fill sequencer for the row/bit register file: writes one bit per clock, then reads
// back every touched row and flags any written bit that does not hold the fill value.
module mem_sweep_ctrl #(
    parameter int unsigned ROWS  = 7,
    parameter int unsigned COLS  = 8,
    parameter int unsigned ROW_W = 3,
    parameter int unsigned COL_W = 3,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [ROW_W-1:0] row_first,
    input  logic [ROW_W-1:0] row_last,
    input  logic [COL_W:0]   col_base,
    input  logic             fill_val,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_bit,
    output logic             wr_data,
    output logic             rd_en,
    output logic [ROW_W-1:0] rd_row,
    input  logic [COLS-1:0]  rd_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mismatch,
    output logic [CNT_W-1:0] wr_count
);

    typedef enum logic [2:0] {StIdle, StWrite, StVerify, StDrain, StDone} state_e;

    function automatic logic [COL_W:0] row_lim(input logic [ROW_W-1:0] row,
                                               input logic [COL_W:0]   base);
        int unsigned sum;
        sum = 32'(row) + 32'(base);
        if (sum > COLS) sum = COLS;
        return (COL_W+1)'(sum);
    endfunction

    function automatic logic [COLS-1:0] lim_mask(input logic [COL_W:0] lim);
        return ~({COLS{1'b1}} << lim);
    endfunction

    state_e           state_q, state_d;
    logic [ROW_W-1:0] first_q, last_q;
    logic [COL_W:0]   base_q;
    logic             fill_q;

    logic             wr_en_q, wr_en_d;
    logic [ROW_W-1:0] wr_row_q, wr_row_d;
    logic [COL_W-1:0] wr_bit_q, wr_bit_d;
    logic             wr_data_q, wr_data_d;
    logic             rd_en_q, rd_en_d;
    logic [ROW_W-1:0] rd_row_q, rd_row_d;
    logic [COLS-1:0]  rd_mask_q, rd_mask_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             mismatch_q;
    logic [CNT_W-1:0] wr_count_q;
    logic             cmp_vld_q;
    logic [COLS-1:0]  cmp_mask_q;

    logic             legal, accept, kill;
    logic [COL_W:0]   base_in;
    logic [ROW_W-1:0] cmd_row0, rd_row0, rd_next;
    logic [COL_W:0]   next_bit;

    always_comb begin
        base_in  = (32'(col_base) > COLS) ? (COL_W+1)'(COLS) : col_base;
        legal    = (row_first <= row_last) && (32'(row_last) < ROWS);
        accept   = (state_q == StIdle) && start && legal;
        kill     = abort && (state_q != StIdle);
        // Only row 0 with a zero offset has an empty limit, so one skip step is enough.
        cmd_row0 = (row_lim(row_first, base_in) == '0) ? row_first + 1'b1 : row_first;
        rd_row0  = (row_lim(first_q, base_q) == '0) ? first_q + 1'b1 : first_q;
        rd_next  = rd_row_q + 1'b1;
        next_bit = {1'b0, wr_bit_q} + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_row_d  = wr_row_q;
        wr_bit_d  = wr_bit_q;
        rd_en_d   = 1'b0;
        rd_row_d  = rd_row_q;
        rd_mask_d = rd_mask_q;
        err_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (!legal) begin
                        err_d = 1'b1;
                    end else if (cmd_row0 > row_last) begin
                        state_d = StDrain;
                    end else begin
                        state_d  = StWrite;
                        wr_en_d  = 1'b1;
                        wr_row_d = cmd_row0;
                        wr_bit_d = '0;
                    end
                end
            end
            StWrite: begin
                if (kill) begin
                    state_d = StIdle;
                end else if (next_bit < row_lim(wr_row_q, base_q)) begin
                    wr_en_d  = 1'b1;
                    wr_bit_d = next_bit[COL_W-1:0];
                end else if (wr_row_q != last_q) begin
                    wr_en_d  = 1'b1;
                    wr_row_d = wr_row_q + 1'b1;
                    wr_bit_d = '0;
                end else begin
                    state_d   = StVerify;
                    rd_en_d   = 1'b1;
                    rd_row_d  = rd_row0;
                    rd_mask_d = lim_mask(row_lim(rd_row0, base_q));
                end
            end
            StVerify: begin
                if (kill) begin
                    state_d = StIdle;
                end else if (rd_row_q != last_q) begin
                    rd_en_d   = 1'b1;
                    rd_row_d  = rd_next;
                    rd_mask_d = lim_mask(row_lim(rd_next, base_q));
                end else begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = kill ? StIdle : StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        wr_data_d = wr_en_d & ((state_q == StIdle) ? fill_val : fill_q);
        busy_d    = (state_d == StWrite) || (state_d == StVerify) || (state_d == StDrain);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_q    <= '0;
            last_q     <= '0;
            base_q     <= '0;
            fill_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_row_q   <= '0;
            wr_bit_q   <= '0;
            wr_data_q  <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_row_q   <= '0;
            rd_mask_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mismatch_q <= 1'b0;
            wr_count_q <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_mask_q <= '0;
        end else begin
            if (accept) begin
                first_q <= row_first;
                last_q  <= row_last;
                base_q  <= base_in;
                fill_q  <= fill_val;
            end
            wr_en_q    <= wr_en_d;
            wr_row_q   <= wr_row_d;
            wr_bit_q   <= wr_bit_d;
            wr_data_q  <= wr_data_d;
            rd_en_q    <= rd_en_d;
            rd_row_q   <= rd_row_d;
            rd_mask_q  <= rd_mask_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            // rd_data answers the read issued one cycle earlier; an abort drops it.
            cmp_vld_q  <= rd_en_q && !kill;
            cmp_mask_q <= rd_mask_q;
            if (accept) begin
                wr_count_q <= '0;
                mismatch_q <= 1'b0;
            end else if (!kill) begin
                if (wr_en_q) wr_count_q <= wr_count_q + 1'b1;
                if (cmp_vld_q && |((rd_data ^ {COLS{fill_q}}) & cmp_mask_q)) begin
                    mismatch_q <= 1'b1;
                end
            end
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_row   = wr_row_q;
    assign wr_bit   = wr_bit_q;
    assign wr_data  = wr_data_q;
    assign rd_en    = rd_en_q;
    assign rd_row   = rd_row_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign mismatch = mismatch_q;
    assign wr_count = wr_count_q;

    a_no_rw_overlap: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && rd_en));

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Bench for mem_sweep_ctrl: a behavioural bit memory with fault injection plus a reference model
// that lists the expected write and read sequence for each command.
module tb_mem_sweep_ctrl;

    localparam int unsigned ROWS  = 7;
    localparam int unsigned COLS  = 8;
    localparam int unsigned ROW_W = 3;
    localparam int unsigned COL_W = 3;
    localparam int unsigned CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             fill_val = 1'b0;
    logic [ROW_W-1:0] row_first = '0;
    logic [ROW_W-1:0] row_last = '0;
    logic [COL_W:0]   col_base = '0;
    logic             wr_en, wr_data, rd_en, busy, done, err, mismatch;
    logic [ROW_W-1:0] wr_row, rd_row;
    logic [COL_W-1:0] wr_bit;
    logic [COLS-1:0]  rd_data = '0;
    logic [CNT_W-1:0] wr_count;

    int n_checks = 0;
    int n_fails = 0;

    // Stuck-bit fault seen by reads
    bit f_en = 1'b0;
    int f_row = 0;
    int f_bit = 0;
    bit f_val = 1'b0;

    // Expected persistent state left by the previous command
    int m_count = 0;
    bit m_mm = 1'b0;
    bit m_mm_known = 1'b1;

    logic [COLS-1:0] mem [ROWS];

    always #5 clk = ~clk;

    mem_sweep_ctrl #(
        .ROWS (ROWS),
        .COLS (COLS),
        .ROW_W(ROW_W),
        .COL_W(COL_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .row_first(row_first),
        .row_last (row_last),
        .col_base (col_base),
        .fill_val (fill_val),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_bit   (wr_bit),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_row   (rd_row),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mismatch (mismatch),
        .wr_count (wr_count)
    );

    function automatic logic [COLS-1:0] read_row(input int r);
        logic [COLS-1:0] w;
        w = mem[r];
        if (f_en && r == f_row) w[f_bit] = f_val;
        return w;
    endfunction

    always @(posedge clk) begin
        if (wr_en) mem[wr_row][wr_bit] <= wr_data;
        if (rd_en) rd_data <= read_row(int'(rd_row));
    end

    function automatic int lim_of(input int i, input int cb);
        return (i + cb < COLS) ? i + cb : COLS;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".wr_en"}, wr_en, 0);
        check_eq({tag, ".wr_row"}, wr_row, 0);
        check_eq({tag, ".wr_bit"}, wr_bit, 0);
        check_eq({tag, ".wr_data"}, wr_data, 0);
        check_eq({tag, ".rd_en"}, rd_en, 0);
        check_eq({tag, ".rd_row"}, rd_row, 0);
        check_eq({tag, ".busy"}, busy, 0);
        check_eq({tag, ".done"}, done, 0);
        check_eq({tag, ".err"}, err, 0);
        check_eq({tag, ".mismatch"}, mismatch, 0);
        check_eq({tag, ".wr_count"}, wr_count, 0);
    endtask

    // kill_kind: 1 = abort, 2 = reset, applied so it is sampled at the end of cycle kill_k.
    task automatic run_sweep(input int first, input int last, input int base, input bit fill,
                             input int kill_k, input int kill_kind);
        int wrow[$];
        int wbit[$];
        int rrow[$];
        int cb, w_n, r_n, ncyc, l, held;
        bit legal, exp_mm, killed, exp_wr, exp_rd;

        legal  = (first <= last) && (last < ROWS);
        cb     = (base > COLS) ? COLS : base;
        exp_mm = 1'b0;
        if (legal) begin
            for (int i = first; i <= last; i++) begin
                l = lim_of(i, cb);
                for (int b = 0; b < l; b++) begin
                    wrow.push_back(i);
                    wbit.push_back(b);
                end
                if (l > 0) rrow.push_back(i);
                if (f_en && f_row == i && f_bit < l && f_val != fill) exp_mm = 1'b1;
            end
        end
        w_n  = wrow.size();
        r_n  = rrow.size();
        held = (kill_k - 1 < w_n) ? kill_k - 1 : w_n;
        ncyc = !legal ? 3 : (kill_k > 0 ? kill_k + 3 : w_n + r_n + 3);

        @(negedge clk);
        start     = 1'b1;
        abort     = 1'($urandom_range(0, 1));
        row_first = ROW_W'(first);
        row_last  = ROW_W'(last);
        col_base  = (COL_W+1)'(base);
        fill_val  = fill;

        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            killed = (kill_k > 0) && (k > kill_k);
            if (!legal) begin
                check_eq("ill.err", err, k == 1);
                check_eq("ill.wr_en", wr_en, 0);
                check_eq("ill.busy", busy, 0);
                check_eq("ill.done", done, 0);
                if (k == 1) begin
                    check_eq("ill.count_hold", wr_count, m_count);
                    if (m_mm_known) check_eq("ill.mm_hold", mismatch, m_mm);
                end
            end else if (killed) begin
                check_eq("kill.wr_en", wr_en, 0);
                check_eq("kill.rd_en", rd_en, 0);
                check_eq("kill.busy", busy, 0);
                check_eq("kill.done", done, 0);
                if (k == kill_k + 1) begin
                    if (kill_kind == 2) check_all_zero("rst");
                    else check_eq("abort.wr_count", wr_count, held);
                end
            end else begin
                exp_wr = (k <= w_n);
                exp_rd = (k > w_n) && (k <= w_n + r_n);
                check_eq("wr_en", wr_en, exp_wr);
                check_eq("rd_en", rd_en, exp_rd);
                check_eq("busy", busy, k <= w_n + r_n + 1);
                check_eq("done", done, k == w_n + r_n + 2);
                check_eq("err", err, 0);
                if (exp_wr) begin
                    check_eq("wr_row", wr_row, wrow[k-1]);
                    check_eq("wr_bit", wr_bit, wbit[k-1]);
                    check_eq("wr_data", wr_data, fill);
                end
                if (exp_rd) check_eq("rd_row", rd_row, rrow[k-w_n-1]);
                if (k == 1) begin
                    check_eq("start.wr_count", wr_count, 0);
                    check_eq("start.mismatch", mismatch, 0);
                end
                if (k == w_n + r_n + 2) begin
                    check_eq("done.mismatch", mismatch, exp_mm);
                    check_eq("done.wr_count", wr_count, w_n);
                end
            end

            start = 1'b0;
            abort = 1'b0;
            // Junk commands while busy must be ignored.
            if (legal && !killed && k < w_n + r_n + 1 && (kill_k == 0 || k < kill_k)) begin
                start     = 1'($urandom_range(0, 1));
                row_first = ROW_W'($urandom);
                row_last  = ROW_W'($urandom);
                col_base  = (COL_W+1)'($urandom);
                fill_val  = 1'($urandom);
            end
            if (legal && kill_k > 0 && k == kill_k) begin
                if (kill_kind == 1) abort = 1'b1;
                else rst_n = 1'b0;
            end
            if (kill_k > 0 && k == kill_k + 1) rst_n = 1'b1;
        end

        if (legal) begin
            if (kill_k == 0) begin
                m_count    = w_n;
                m_mm       = exp_mm;
                m_mm_known = 1'b1;
            end else if (kill_kind == 1) begin
                m_count    = held;
                m_mm_known = 1'b0;
            end else begin
                m_count    = 0;
                m_mm       = 1'b0;
                m_mm_known = 1'b1;
            end
        end
    endtask

    initial begin
        int a, b;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        run_sweep(0, 4, 4, 1'b1, 0, 0);
        run_sweep(0, 4, 0, 1'b0, 0, 0);

        f_en = 1'b1; f_row = 3; f_bit = 2; f_val = 1'b1;
        run_sweep(0, 4, 4, 1'b0, 0, 0);
        f_bit = 7;
        run_sweep(0, 4, 4, 1'b0, 0, 0);
        f_en = 1'b0;

        run_sweep(5, 2, 4, 1'b1, 0, 0);
        run_sweep(0, 7, 4, 1'b1, 0, 0);

        run_sweep(0, 4, 4, 1'b1, 10, 1);
        run_sweep(0, 4, 4, 1'b1, 0, 0);
        run_sweep(0, 4, 4, 1'b1, 32, 2);
        run_sweep(0, 0, 0, 1'b1, 0, 0);
        run_sweep(2, 6, 12, 1'b0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            f_en  = 1'($urandom_range(0, 1));
            f_row = $urandom_range(0, ROWS - 1);
            f_bit = $urandom_range(0, COLS - 1);
            f_val = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 7);
            b = $urandom_range(0, 7);
            if (a > b && $urandom_range(0, 3) != 0) begin
                int t;
                t = a; a = b; b = t;
            end
            run_sweep(a, b, $urandom_range(0, 15), 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
